// File: rtl/bcd_seq_decoder.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with registered
// active-low seven-segment outputs. Define BCD_LEADING_ZERO_BLANK_EN to blank leading zeros.
module bcd_seq_decoder #(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 5,
    parameter int SEGMENTS = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [WIDTH-1:0]             num,
    output logic                         busy,
    output logic                         done,
    output logic [4*DIGITS-1:0]          bcd,
    output logic                         ovf,
    output logic [SEGMENTS*DIGITS-1:0]   Sseg
);

    localparam int              CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   WIDTH_C = CW'(WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] DASH  = 7'h3F;

    if (SEGMENTS != 7) begin : g_seg_check
        $error("bcd_seq_decoder supports SEGMENTS == 7 only");
    end

    logic [1:0]                  state;
    logic [WIDTH-1:0]            shreg;
    logic [4*DIGITS-1:0]         scratch;
    logic                        ovf_s;
    logic [CW-1:0]               cnt;

    logic [4*DIGITS-1:0]         adj;
    logic [4*DIGITS-1:0]         scratch_nx;
    logic [SEGMENTS*DIGITS-1:0]  sseg_nx;
    logic [6:0]                  code;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic                        leading;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = BLANK;
        endcase
    endfunction

    // Add-3 correction, then the scratch takes the top bit of the shift register.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
        scratch_nx = {adj[4*DIGITS-2:0], shreg[WIDTH-1]};
    end

    // Digits scanned from the top so leading-zero state is known on the way down.
    always_comb begin
        sseg_nx = '0;
        code    = BLANK;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        leading = 1'b1;
`endif
        for (int i = DIGITS - 1; i >= 0; i--) begin
            code = seg7(scratch[4*i +: 4]);
`ifdef BCD_LEADING_ZERO_BLANK_EN
            if (scratch[4*i +: 4] != 4'd0 || i == 0)
                leading = 1'b0;
            if (leading)
                code = BLANK;
`endif
            if (ovf_s)
                code = DASH;
            sseg_nx[SEGMENTS*i +: 7] = code;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            scratch <= '0;
            ovf_s   <= 1'b0;
            cnt     <= '0;
            bcd     <= '0;
            ovf     <= 1'b0;
            Sseg    <= {DIGITS{BLANK}};
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= num;
                        scratch <= '0;
                        ovf_s   <= 1'b0;
                        cnt     <= WIDTH_C;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg   <= shreg << 1;
                    scratch <= scratch_nx;
                    ovf_s   <= ovf_s | adj[4*DIGITS-1];
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= DONE;
                end
                DONE: begin
                    bcd   <= scratch;
                    ovf   <= ovf_s;
                    Sseg  <= sseg_nx;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_bcd_seq_decoder.sv
// Directed bench for bcd_seq_decoder: default instance plus a DIGITS=3 instance for overflow.
// Expected segment codes follow BCD_LEADING_ZERO_BLANK_EN when it is defined.
module tb_bcd_seq_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start3;
    logic [15:0] num, num3;

    logic        busy, done, ovf;
    logic [19:0] bcd;
    logic [34:0] sseg;
    logic        busy3, done3, ovf3;
    logic [11:0] bcd3;
    logic [20:0] sseg3;

    bcd_seq_decoder u_dut (
        .clk(clk), .rst(rst), .start(start), .num(num),
        .busy(busy), .done(done), .bcd(bcd), .ovf(ovf), .Sseg(sseg)
    );

    bcd_seq_decoder #(.WIDTH(16), .DIGITS(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .num(num3),
        .busy(busy3), .done(done3), .bcd(bcd3), .ovf(ovf3), .Sseg(sseg3)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [34:0] pick5(input logic [34:0] full, input logic [34:0] lz);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        return lz;
`else
        return full;
`endif
    endfunction

    function automatic logic [20:0] pick3(input logic [20:0] full, input logic [20:0] lz);
`ifdef BCD_LEADING_ZERO_BLANK_EN
        return lz;
`else
        return full;
`endif
    endfunction

    function automatic logic [19:0] to_bcd5(input int unsigned n);
        logic [19:0] r;
        int unsigned v;
        r = '0;
        v = n;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    typedef struct {
        logic [15:0] n;
        logic [19:0] bcd;
        logic        ovf;
        logic [34:0] seg_full;
        logic [34:0] seg_lz;
    } vec5_t;

    typedef struct {
        logic [15:0] n;
        logic [11:0] bcd;
        logic        ovf;
        logic [20:0] seg_full;
        logic [20:0] seg_lz;
    } vec3_t;

    vec5_t v5[8];
    vec3_t v3[4];

    // Start one conversion on the chosen instance; lat = edges from accept to done (41 = timeout).
    task automatic run_conv(input bit which, input logic [15:0] n, output int lat);
        @(negedge clk);
        if (which) begin start3 = 1'b1; num3 = n; end
        else       begin start  = 1'b1; num  = n; end
        @(posedge clk);
        #1;
        check("busy_after_accept", 64'(which ? busy3 : busy), 64'(1));
        start  = 1'b0;
        start3 = 1'b0;
        lat = 0;
        while (lat <= 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (which ? done3 : done) break;
        end
        check("busy_in_done_cycle", 64'(which ? busy3 : busy), 64'(0));
    endtask

    initial begin
        int lat;
        int dcount;
        logic [15:0] nums[56];

        v5[0] = '{16'd255,   20'h00255, 1'b0, {7'h40,7'h40,7'h24,7'h12,7'h12}, {7'h7F,7'h7F,7'h24,7'h12,7'h12}};
        v5[1] = '{16'd65535, 20'h65535, 1'b0, {7'h02,7'h12,7'h12,7'h30,7'h12}, {7'h02,7'h12,7'h12,7'h30,7'h12}};
        v5[2] = '{16'd0,     20'h00000, 1'b0, {7'h40,7'h40,7'h40,7'h40,7'h40}, {7'h7F,7'h7F,7'h7F,7'h7F,7'h40}};
        v5[3] = '{16'd1,     20'h00001, 1'b0, {7'h40,7'h40,7'h40,7'h40,7'h79}, {7'h7F,7'h7F,7'h7F,7'h7F,7'h79}};
        v5[4] = '{16'd10000, 20'h10000, 1'b0, {7'h79,7'h40,7'h40,7'h40,7'h40}, {7'h79,7'h40,7'h40,7'h40,7'h40}};
        v5[5] = '{16'd9999,  20'h09999, 1'b0, {7'h40,7'h10,7'h10,7'h10,7'h10}, {7'h7F,7'h10,7'h10,7'h10,7'h10}};
        v5[6] = '{16'd1234,  20'h01234, 1'b0, {7'h40,7'h79,7'h24,7'h30,7'h19}, {7'h7F,7'h79,7'h24,7'h30,7'h19}};
        v5[7] = '{16'd8075,  20'h08075, 1'b0, {7'h40,7'h00,7'h40,7'h78,7'h12}, {7'h7F,7'h00,7'h40,7'h78,7'h12}};

        v3[0] = '{16'd1000,  12'h000, 1'b1, {7'h3F,7'h3F,7'h3F}, {7'h3F,7'h3F,7'h3F}};
        v3[1] = '{16'd999,   12'h999, 1'b0, {7'h10,7'h10,7'h10}, {7'h10,7'h10,7'h10}};
        v3[2] = '{16'd65535, 12'h535, 1'b1, {7'h3F,7'h3F,7'h3F}, {7'h3F,7'h3F,7'h3F}};
        v3[3] = '{16'd7,     12'h007, 1'b0, {7'h40,7'h40,7'h78}, {7'h7F,7'h7F,7'h78}};

        rst = 1'b1; start = 1'b0; start3 = 1'b0; num = '0; num3 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_ovf",  64'(ovf),  64'(0));
        check("reset_bcd",  64'(bcd),  64'(0));
        check("reset_sseg", 64'(sseg), 64'({5{7'h7F}}));
        check("reset_sseg3", 64'(sseg3), 64'({3{7'h7F}}));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_conv(1'b0, v5[i].n, lat);
            check("latency5", 64'(lat), 64'(17));
            check("bcd5",  64'(bcd),  64'(v5[i].bcd));
            check("ovf5",  64'(ovf),  64'(v5[i].ovf));
            check("sseg5", 64'(sseg), 64'(pick5(v5[i].seg_full, v5[i].seg_lz)));
        end

        // Results hold between done pulses.
        repeat (5) @(posedge clk);
        #1;
        check("hold_bcd",  64'(bcd),  64'(v5[7].bcd));
        check("hold_done", 64'(done), 64'(0));

        for (int i = 0; i < 4; i++) begin
            run_conv(1'b1, v3[i].n, lat);
            check("latency3", 64'(lat), 64'(17));
            check("bcd3",  64'(bcd3),  64'(v3[i].bcd));
            check("ovf3",  64'(ovf3),  64'(v3[i].ovf));
            check("sseg3", 64'(sseg3), 64'(pick3(v3[i].seg_full, v3[i].seg_lz)));
        end

        // Start while busy is ignored, not queued.
        @(negedge clk); start = 1'b1; num = 16'd1234;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; num = 16'd999;
        @(negedge clk); start = 1'b0;
        lat = 0;
        while (lat <= 40 && !done) begin @(posedge clk); #1; lat++; end
        check("ignore_done_seen", 64'(done), 64'(1));
        check("ignore_bcd", 64'(bcd), 64'(20'h01234));
        dcount = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check("ignore_no_second_done", 64'(dcount), 64'(0));

        // Start held high with num changing each cycle: accepts at edges 0, 18, 36, 54.
        for (int t = 0; t < 56; t++) begin
            @(negedge clk);
            nums[t] = 16'(1000 + 997 * t);
            start = 1'b1;
            num   = nums[t];
            @(posedge clk);
            #1;
            if (t == 17 || t == 35 || t == 53) begin
                check("cont_done", 64'(done), 64'(1));
                check("cont_bcd", 64'(bcd), 64'(to_bcd5(32'(nums[t-17]))));
            end else begin
                check("cont_no_done", 64'(done), 64'(0));
            end
        end
        @(negedge clk); start = 1'b0;
        lat = 0;
        while (lat <= 40 && !done) begin @(posedge clk); #1; lat++; end
        check("cont_last_bcd", 64'(bcd), 64'(to_bcd5(32'(nums[54]))));

        // Reset in the middle of a conversion.
        @(negedge clk); start = 1'b1; num = 16'd4321;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_sseg", 64'(sseg), 64'({5{7'h7F}}));
        check("abort_bcd",  64'(bcd),  64'(0));
        dcount = 0;
        repeat (3) begin @(posedge clk); #1; if (done) dcount++; end
        check("abort_no_done", 64'(dcount), 64'(0));

        // Start accepted on the first edge after reset release.
        @(negedge clk);
        rst = 1'b0; start = 1'b1; num = 16'd777;
        @(posedge clk);
        #1;
        check("post_reset_accept", 64'(busy), 64'(1));
        start = 1'b0;
        lat = 0;
        while (lat <= 40) begin
            @(posedge clk); #1; lat++;
            if (done) break;
        end
        check("post_reset_latency", 64'(lat), 64'(17));
        check("post_reset_bcd", 64'(bcd), 64'(20'h00777));
        check("post_reset_sseg", 64'(sseg),
              64'(pick5({7'h40,7'h40,7'h78,7'h78,7'h78}, {7'h7F,7'h7F,7'h78,7'h78,7'h78})));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bcd_seq_decoder.md
BCD_SEQ_DECODER -- requirements
Module: bcd_seq_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning binary input width in bits (1..32).
REQ-002 SHALL have parameter DIGITS, default 5, meaning number of BCD digits and seven-segment displays (1..10).
REQ-003 SHALL have parameter SEGMENTS, default 7, meaning segments per display; only 7 is supported.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset: asynchronous, active-high.
REQ-006 SHALL have port start, input, 1, meaning request a conversion of num.
REQ-007 SHALL have port num, input, WIDTH, meaning unsigned binary value, sampled only when start is accepted.
REQ-008 SHALL have port busy, output, 1, meaning high while a conversion is in progress.
REQ-009 SHALL have port done, output, 1, meaning one-cycle pulse when the results update.
REQ-010 SHALL have port bcd, output, 4*DIGITS, meaning registered BCD result, digit 0 (units) in bits [3:0].
REQ-011 SHALL have port ovf, output, 1, meaning the last converted value exceeds 10^DIGITS-1.
REQ-012 SHALL have port Sseg, output, SEGMENTS*DIGITS, meaning registered active-low segment codes, digit 0 in bits [6:0], bit order gfedcba.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 SHALL accept start only in IDLE; start in SHIFT or DONE is ignored, not queued.
REQ-015 SHALL, on acceptance, capture num into a shift register, clear the BCD scratch and ovf scratch, load the bit counter with WIDTH, and enter SHIFT.
REQ-016 SHALL, in each SHIFT cycle, add 3 to every scratch digit >= 5, then shift {scratch, shift register} left by one bit, then decrement the counter.
REQ-017 SHALL set ovf scratch if a 1 is shifted out of the top scratch digit in any SHIFT cycle.
REQ-018 SHALL leave SHIFT for DONE after exactly WIDTH SHIFT cycles.
REQ-019 SHALL, in DONE, load bcd, ovf and Sseg from the scratch, pulse done for that one cycle, and return to IDLE.
REQ-020 SHALL hold busy high in SHIFT and DONE and low in IDLE.
REQ-021 SHALL make done high exactly WIDTH+1 cycles after the edge that accepted start, with a back-to-back start accepted no earlier than WIDTH+2 cycles after the previous one.
REQ-022 SHALL hold bcd, ovf and Sseg stable between done pulses.
REQ-023 SHALL encode digits as 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, and use blank=0x7F.
REQ-024 SHALL drive every digit as dash (0x3F) when ovf is set; bcd still holds the truncated low DIGITS digits.
REQ-025 SHALL handle num=0 and num=2^WIDTH-1 without special-casing.

Reset
REQ-026 SHALL, on rst high, immediately enter IDLE, with busy=0, done=0, ovf=0, bcd=0, and every Sseg digit blank (0x7F).
REQ-027 SHALL abort a conversion interrupted by reset, with no done pulse and outputs at their reset values.
REQ-028 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-029 SHALL, when macro BCD_LEADING_ZERO_BLANK_EN is defined, blank (0x7F) every zero digit above the most significant nonzero digit; digit 0 is always shown, and ovf dash display takes priority.
REQ-030 SHALL, without BCD_LEADING_ZERO_BLANK_EN, display every digit including leading zeros.

Verification
REQ-031 SHALL check: defaults, num=255, start 1 cycle -> done at cycle 17, bcd=0x00255, ovf=0, Sseg digit0=0x12, digit1=0x12, digit2=0x24.
REQ-032 SHALL check: defaults, num=65535 -> bcd=0x65535, ovf=0; num=0 -> bcd=0, digit0=0x40, digits1-4 =0x7F with macro, =0x40 without.
REQ-033 SHALL check: DIGITS=3, WIDTH=16, num=1000 -> ovf=1, bcd=0x000, all three digits 0x3F.
REQ-034 SHALL check: start held high continuously with num changing -> conversions every WIDTH+2 cycles, each result matching the num sampled at acceptance.
REQ-035 SHALL check: rst pulsed at SHIFT cycle 8 -> busy=0 immediately, no done, Sseg all 0x7F, next start converts correctly.
